// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the fetch stage: opcode field values, the NOP word and FSM states.
package instruction_fetch_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SUBI  = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // RTYPE sll $0,$0,0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      FETCH_REQ = 1'b0,
      SKID      = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise holds. pc4 survives a flush.
module instruction_fetch_if_id_reg #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc4_in,
   output logic        valid,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [31:0] pc4
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
         pc4   <= 32'h0000_0000;
      end else if (flush) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
      end else if (load) begin
         valid <= 1'b1;
         instr <= instr_in;
         pc4   <= pc4_in;
      end
   end

   assign opcode = instr[31:26];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, req/ack fetch FSM with a one-word skid buffer, beq/j redirect with kill.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_bubble_cnt outputs.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = instruction_fetch_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        j,
   input  logic [25:0] j_index,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [5:0]  if_id_opcode,
   output logic [31:0] if_id_pc4
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_bubble_cnt
`endif
);

   import instruction_fetch_pkg::*;

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d, pc_plus4;
   logic [31:0]  hold_addr_q, hold_addr_d;
   logic         req_q, req_d;
   logic         kill_q, kill_d;
   logic         skid_valid_q, skid_valid_d;
   logic [31:0]  skid_instr_q, skid_instr_d;
   logic [31:0]  skid_pc4_q, skid_pc4_d;

   logic         redirect;
   logic [31:0]  target;
   logic         ack_v, ack_live;
   logic         ifid_load, ifid_flush;
   logic [31:0]  ifid_instr_in, ifid_pc4_in;

   assign redirect = branch_taken | j;
   assign target   = branch_taken ? (branch_target & 32'hFFFF_FFFC)
                                  : {if_id_pc4[31:28], j_index, 2'b00};
   assign pc_plus4 = pc_q + 32'd4;
   assign ack_v    = req_q & imem_ack;
   assign ack_live = ack_v & ~kill_q;

   assign imem_req  = req_q;
   // A killed request keeps its original address until its ack retires it.
   assign imem_addr = kill_q ? hold_addr_q : pc_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      req_d         = req_q;
      kill_d        = kill_q;
      hold_addr_d   = hold_addr_q;
      skid_valid_d  = skid_valid_q;
      skid_instr_d  = skid_instr_q;
      skid_pc4_d    = skid_pc4_q;
      ifid_load     = 1'b0;
      ifid_flush    = 1'b0;
      ifid_instr_in = imem_rdata;
      ifid_pc4_in   = pc_plus4;

      unique case (state_q)
         FETCH_REQ: begin
            req_d = 1'b1;
            if (ack_v) kill_d = 1'b0;
            if (ack_live && !redirect) begin
               pc_d = pc_plus4;
               if (stall) begin
                  state_d      = SKID;
                  req_d        = 1'b0;
                  skid_valid_d = 1'b1;
                  skid_instr_d = imem_rdata;
                  skid_pc4_d   = pc_plus4;
               end else begin
                  ifid_load = 1'b1;
               end
            end
         end
         SKID: begin
            if (!stall && skid_valid_q) begin
               ifid_load     = 1'b1;
               ifid_instr_in = skid_instr_q;
               ifid_pc4_in   = skid_pc4_q;
               skid_valid_d  = 1'b0;
               state_d       = FETCH_REQ;
               req_d         = 1'b1;
            end
         end
      endcase

      // Decode consumed the slot and nothing new arrived: insert a bubble.
      if (!ifid_load && !stall) ifid_flush = 1'b1;

      if (redirect) begin
         pc_d         = target;
         ifid_load    = 1'b0;
         ifid_flush   = 1'b1;
         skid_valid_d = 1'b0;
         state_d      = FETCH_REQ;
         req_d        = 1'b1;
         if (req_q && !imem_ack) begin
            kill_d = 1'b1;
            if (!kill_q) hold_addr_d = pc_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FETCH_REQ;
         pc_q         <= RESET_PC;
         req_q        <= 1'b0;
         kill_q       <= 1'b0;
         hold_addr_q  <= RESET_PC;
         skid_valid_q <= 1'b0;
         skid_instr_q <= NOP_INSTR;
         skid_pc4_q   <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_q        <= req_d;
         kill_q       <= kill_d;
         hold_addr_q  <= hold_addr_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
      end
   end

   instruction_fetch_if_id_reg #(
      .NOP_INSTR(NOP_INSTR)
   ) u_if_id_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (ifid_load),
      .flush    (ifid_flush),
      .instr_in (ifid_instr_in),
      .pc4_in   (ifid_pc4_in),
      .valid    (if_id_valid),
      .instr    (if_id_instr),
      .opcode   (if_id_opcode),
      .pc4      (if_id_pc4)
   );

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt  <= 32'h0000_0000;
         perf_bubble_cnt <= 32'h0000_0000;
      end else begin
         if (ack_live) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (!if_id_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: memory responder, intent scoreboard, program-order model.
module tb_instruction_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   typedef struct {
      bit          br;
      logic [31:0] bt;
      logic [25:0] ji;
   } intent_t;

   logic        clk = 1'b0;
   logic        rst, stall, branch_taken, j;
   logic [31:0] branch_target;
   logic [25:0] j_index;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        if_id_valid;
   logic [31:0] if_id_instr, if_id_pc4;
   logic [5:0]  if_id_opcode;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

   int          tests = 0;
   int          fails = 0;
   int          consumed = 0;
   int unsigned salt = 0;
   int          lat_mode = 1;
   bit          slow_0x10 = 0;
   intent_t     intent_q[$];

   instruction_fetch #(
      .RESET_PC (RESET_PC),
      .NOP_INSTR(NOP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .j            (j),
      .j_index      (j_index),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .if_id_valid  (if_id_valid),
      .if_id_instr  (if_id_instr),
      .if_id_opcode (if_id_opcode),
      .if_id_pc4    (if_id_pc4)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_bubble_cnt(perf_bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ((a ^ salt) * 32'h9E37_79B1) + 32'h0123_4567;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit s, input bit br, input logic [31:0] bt, input bit jj,
                        input logic [25:0] ji);
      intent_t it;
      stall         = s;
      branch_taken  = br;
      branch_target = bt;
      j             = jj;
      j_index       = ji;
      if (br || jj) begin
         it.br = br;
         it.bt = bt;
         it.ji = ji;
         intent_q.push_back(it);
      end
   endtask

   // Instruction memory: acks each request after a configurable number of cycles.
   initial begin : responder
      int          cnt;
      bit          busy;
      logic [31:0] a;
      busy = 0;
      cnt  = 0;
      a    = 0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      forever begin
         cyc();
         if (rst) begin
            busy     = 0;
            imem_ack = 1'b0;
         end else begin
            if (imem_ack) begin
               imem_ack = 1'b0;
               busy     = 0;
            end
            if (imem_req && !busy) begin
               busy = 1;
               a    = imem_addr;
               cnt  = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
               if (slow_0x10 && a == 32'h10) cnt = 4;
            end else if (busy) begin
               if (cnt <= 1) begin
                  imem_ack   = 1'b1;
                  imem_rdata = mem_word(a);
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   // Model: decode sees instructions in program order; a redirect restarts the order at its target.
   initial begin : monitor
      logic [31:0] exp_pc, last_pc4, prev_addr, w, tgt;
      bit          prev_pend;
      int          idle;
      intent_t     it;
      exp_pc    = RESET_PC;
      last_pc4  = 32'h0;
      prev_addr = 32'h0;
      prev_pend = 0;
      idle      = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_pc    = RESET_PC;
            last_pc4  = 32'h0;
            prev_pend = 0;
            idle      = 0;
         end else begin
            if (prev_pend) begin
               check("req_held", {31'h0, imem_req}, 32'h1);
               check("addr_stable", imem_addr, prev_addr);
            end
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (imem_req) check("addr_aligned", {30'h0, imem_addr[1:0]}, 32'h0);

            if (if_id_valid) begin
               w = mem_word(exp_pc);
               check("if_id_pc4", if_id_pc4, exp_pc + 32'd4);
               check("if_id_instr", if_id_instr, w);
               check("if_id_opcode", {26'h0, if_id_opcode}, {26'h0, w[31:26]});
               last_pc4 = exp_pc + 32'd4;
               if (!stall) begin
                  exp_pc = exp_pc + 32'd4;
                  consumed++;
               end
            end else begin
               check("bubble_instr", if_id_instr, NOP);
            end

            if (!stall) idle = if_id_valid ? 0 : idle + 1;
            if (idle > 60) begin
               check("progress_idle_cycles", idle, 0);
               idle = 0;
            end

            if (branch_taken || j) begin
               if (intent_q.size() == 0) begin
                  check("intent_queue_nonempty", 32'h0, 32'h1);
               end else begin
                  it  = intent_q.pop_front();
                  tgt = it.br ? (it.bt & 32'hFFFF_FFFC) : {last_pc4[31:28], it.ji, 2'b00};
                  exp_pc = tgt;
               end
            end
         end
      end
   end

   initial begin : stimulus
      bit found;
      int r;
      salt = $urandom;
      rst  = 1'b1;
      drive(0, 0, 32'h0, 0, 26'h0);
      cyc();
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_valid", {31'h0, if_id_valid}, 32'h0);
      check("rst_instr", if_id_instr, NOP);
      check("rst_pc4", if_id_pc4, 32'h0);
      cyc();
      @(negedge clk);
      #1 rst = 1'b0;
      check("req_low_before_first_edge", {31'h0, imem_req}, 32'h0);
      cyc();
      check("first_req", {31'h0, imem_req}, 32'h1);
      check("first_addr", imem_addr, RESET_PC);

      // 1-cycle acks; the request to 0x10 is slow and gets redirected to 0x40.
      slow_0x10 = 1;
      lat_mode  = 1;
      found     = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (imem_req && imem_addr == 32'h10) found = 1;
         else cyc();
      end
      check("reached_0x10", {31'h0, found}, 32'h1);
      drive(0, 1, 32'h40, 0, 26'h0);
      cyc();
      drive(0, 0, 32'h0, 0, 26'h0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (imem_req && imem_addr != 32'h10) found = 1;
         else cyc();
      end
      check("addr_after_kill", imem_addr, 32'h40);
      slow_0x10 = 0;

      lat_mode = 3;
      repeat (30) cyc();

      // Stall windows of 4 cycles with acks landing inside them.
      lat_mode = 0;
      repeat (6) begin
         repeat (3) cyc();
         drive(1, 0, 32'h0, 0, 26'h0);
         repeat (4) cyc();
         drive(0, 0, 32'h0, 0, 26'h0);
      end

      // Random mix of stalls, branches, jumps and both at once.
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 99));
         drive(($urandom_range(0, 3) == 0),
               (r < 5),
               ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_0FFF),
               (r >= 3 && r < 8),
               26'($urandom));
         cyc();
      end
      drive(0, 0, 32'h0, 0, 26'h0);
      repeat (10) cyc();

      // Jump from if_id_pc4 = 0x1000_0008.
      lat_mode = 1;
      drive(0, 1, 32'h1000_0004, 0, 26'h0);
      cyc();
      drive(0, 0, 32'h0, 0, 26'h0);
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (if_id_valid && if_id_pc4 == 32'h1000_0008) found = 1;
         else cyc();
      end
      check("reached_pc4_10000008", {31'h0, found}, 32'h1);
      drive(0, 0, 32'h0, 1, 26'h10);
      cyc();
      drive(0, 0, 32'h0, 0, 26'h0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (imem_req && imem_addr == 32'h1000_0040) found = 1;
         else cyc();
      end
      check("jump_addr_10000040", {31'h0, found}, 32'h1);

      // Branch and jump together: branch wins.
      repeat (3) cyc();
      drive(0, 1, 32'h200, 1, 26'h3F0);
      cyc();
      drive(0, 0, 32'h0, 0, 26'h0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (imem_req && imem_addr == 32'h200) found = 1;
         else cyc();
      end
      check("branch_beats_jump", {31'h0, found}, 32'h1);
      repeat (10) cyc();

      // Asynchronous reset in the middle of an outstanding request.
      lat_mode = 3;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (imem_req) found = 1;
         else cyc();
      end
      #2 rst = 1'b1;
      #1;
      check("midrst_req", {31'h0, imem_req}, 32'h0);
      check("midrst_valid", {31'h0, if_id_valid}, 32'h0);
      check("midrst_instr", if_id_instr, NOP);
      check("midrst_pc4", if_id_pc4, 32'h0);
      cyc();
      cyc();
      @(negedge clk);
      #1 rst = 1'b0;
      cyc();
      check("post_rst_req", {31'h0, imem_req}, 32'h1);
      check("post_rst_addr", imem_addr, RESET_PC);
      lat_mode = 0;
      repeat (40) cyc();

      check("enough_consumed", {31'h0, (consumed > 100)}, 32'h1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
